// File: rtl/softproc_debug_jtag_host.sv
// Virtual-JTAG initiator for the Nios II CPU debug slave: runs IR/DR scans with a
// divided TCK and the UIR/CDR/SDR/UDR/RTI strobes, and returns the captured TDO bits.
module softproc_debug_jtag_host #(
    parameter int SR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_dr,
    input  logic                cmd_ir_only,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_W = $clog2(SR_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RSP
    } state_e;

    state_e              state_q;
    state_e              scan_next;
    logic [DIV_W-1:0]    div_q;
    logic [CNT_W-1:0]    bit_q;
    logic                tck_q;
    logic                tdi_q;
    logic                ir_only_q;
    logic                rsp_valid_q;
    logic [1:0]          ir_in_q;
    logic [1:0]          rsp_ir_q;
    logic [4:0]          strobe_q;
    logic [SR_WIDTH-1:0] sr_q;
    logic [SR_WIDTH-1:0] cap_q;
    logic                div_end;
    logic                tck_rise;
    logic                period_end;

    // Strobe vector order: {rti, udr, sdr, cdr, uir}.
    function automatic logic [4:0] strobe_of(input state_e s);
        case (s)
            S_UIR:   return 5'b00001;
            S_CDR:   return 5'b00010;
            S_SHIFT: return 5'b00100;
            S_UDR:   return 5'b01000;
            S_RTI:   return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    assign div_end    = (div_q == DIV_W'(TCK_DIV - 1));
    assign tck_rise   = div_end & ~tck_q;
    assign period_end = div_end & tck_q;

    always_comb begin
        scan_next = S_IDLE;
        case (state_q)
            S_UIR:   scan_next = ir_only_q ? S_RTI : S_CDR;
            S_CDR:   scan_next = S_SHIFT;
            S_SHIFT: scan_next = (bit_q == CNT_W'(1)) ? S_UDR : S_SHIFT;
            S_UDR:   scan_next = S_RTI;
            S_RTI:   scan_next = S_RSP;
            default: scan_next = S_IDLE;
        endcase
    end

    // NOTE: the shift and capture datapath is reset too, so an aborted scan can never leak into a later response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            ir_only_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ir_in_q     <= '0;
            rsp_ir_q    <= '0;
            strobe_q    <= '0;
            sr_q        <= '0;
            cap_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q   <= S_UIR;
                        strobe_q  <= strobe_of(S_UIR);
                        ir_in_q   <= cmd_ir;
                        sr_q      <= cmd_dr;
                        cap_q     <= '0;
                        ir_only_q <= cmd_ir_only;
                        div_q     <= '0;
                        tck_q     <= 1'b0;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    if (div_end) begin
                        div_q <= '0;
                        tck_q <= ~tck_q;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                    if (tck_rise && state_q == S_UIR) begin
                        rsp_ir_q <= vji_ir_out;
                    end
                    if (tck_rise && state_q == S_SHIFT) begin
                        cap_q <= {vji_tdo, cap_q[SR_WIDTH-1:1]};
                        sr_q  <= {1'b0, sr_q[SR_WIDTH-1:1]};
                    end
                    // Period boundary: TCK falls, next phase begins with TCK low and TDI settled.
                    if (period_end) begin
                        state_q  <= scan_next;
                        strobe_q <= strobe_of(scan_next);
                        tdi_q    <= (scan_next == S_SHIFT) ? sr_q[0] : 1'b0;
                        if (state_q == S_CDR) begin
                            bit_q <= CNT_W'(SR_WIDTH);
                        end else if (state_q == S_SHIFT) begin
                            bit_q <= bit_q - 1'b1;
                        end
                        if (scan_next == S_RSP) begin
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = cap_q;
    assign rsp_ir_out = rsp_ir_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = strobe_q[0];
    assign vji_cdr    = strobe_q[1];
    assign vji_sdr    = strobe_q[2];
    assign vji_udr    = strobe_q[3];
    assign vji_rti    = strobe_q[4];

endmodule

// File: tb/tb_softproc_debug_jtag_host.sv
// Directed bench for softproc_debug_jtag_host: a default instance with a one-TCK
// loopback slave and a TCK_DIV=1 instance for the back-to-back handshake.
module tb_softproc_debug_jtag_host;

    localparam int W = 38;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals.
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_ir = '0;
    logic [W-1:0] cmd_dr = '0;
    logic         cmd_ir_only = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_dr;
    logic [1:0]   rsp_ir_out;
    logic         vji_tck, vji_tdi, vji_tdo;
    logic [1:0]   vji_ir_in;
    logic [1:0]   vji_ir_out = '0;
    logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic         lb_q = 1'b0;

    // TCK_DIV = 1 instance signals.
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [1:0]   b_ir = '0;
    logic [W-1:0] b_dr = '0;
    logic         b_rsp_valid;
    logic         b_rsp_ready = 1'b0;
    logic [W-1:0] b_rsp_dr;
    logic [1:0]   b_rsp_ir;
    logic         b_tck, b_tdi;
    logic [1:0]   b_ir_in;
    logic         b_uir, b_cdr, b_sdr, b_udr, b_rti;

    int n_checks = 0;
    int n_errors = 0;
    int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_tck, n_overlap;
    int lat, bad;

    // Loopback slave: TDO is TDI delayed by one TCK period.
    always @(posedge vji_tck) lb_q <= vji_tdi;
    assign vji_tdo = lb_q;

    softproc_debug_jtag_host dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .cmd_ir_only(cmd_ir_only), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    softproc_debug_jtag_host #(.SR_WIDTH(W), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_ir(b_ir), .cmd_dr(b_dr),
        .cmd_ir_only(1'b0), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir), .vji_tck(b_tck), .vji_tdi(b_tdi),
        .vji_tdo(1'b0), .vji_ir_in(b_ir_in), .vji_ir_out(2'b00),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr),
        .vji_rti(b_rti)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the default instance until rsp_valid, counting strobes at each TCK rise.
    task automatic wait_rsp_a(output int cycles);
        logic prev;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_tck = 0; n_overlap = 0;
        prev = vji_tck;
        cycles = 0;
        while (!rsp_valid && cycles < 1000) begin
            step();
            cycles++;
            if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_overlap++;
            if (vji_tck && !prev) begin
                n_tck++;
                if (vji_uir) n_uir++;
                if (vji_cdr) n_cdr++;
                if (vji_sdr) n_sdr++;
                if (vji_udr) n_udr++;
                if (vji_rti) n_rti++;
            end
            prev = vji_tck;
        end
    endtask

    // Runs the TCK_DIV=1 instance until rsp_valid, counting strobe-high clk cycles.
    task automatic wait_rsp_b(output int cycles);
        n_uir = b_uir ? 1 : 0;
        n_sdr = 0;
        cycles = 0;
        while (!b_rsp_valid && cycles < 1000) begin
            step();
            cycles++;
            if (b_uir) n_uir++;
            if (b_sdr) n_sdr++;
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_tck", vji_tck, 1'b0);
        check("rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 5'b0);
        check("rst_tdi_ir_in", {vji_tdi, vji_ir_in}, 3'b0);
        check("rst_rsp_dr", rsp_dr, '0);
        reset_n = 1'b1;
        step();

        // Loopback DR scan.
        vji_ir_out = 2'b01;
        cmd_ir = 2'b01;
        cmd_dr = 38'h2A_5A5A_5A5A;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("lb_uir_cycle1", vji_uir, 1'b1);
        check("lb_ir_in", vji_ir_in, 2'b01);
        check("lb_busy", cmd_ready, 1'b0);
        wait_rsp_a(lat);
        check("lb_latency", lat, 168);
        check("lb_rsp_dr", rsp_dr, 38'h14_B4B4_B4B4);
        check("lb_rsp_ir_out", rsp_ir_out, 2'b01);
        check("cnt_uir", n_uir, 1);
        check("cnt_cdr", n_cdr, 1);
        check("cnt_sdr", n_sdr, 38);
        check("cnt_udr", n_udr, 1);
        check("cnt_rti", n_rti, 1);
        check("cnt_total", n_tck, 42);
        check("cnt_overlap", n_overlap, 0);

        // Backpressure: response held for 50 cycles.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_dr !== 38'h14_B4B4_B4B4 || cmd_ready !== 1'b0 ||
                vji_tck !== 1'b0)
                bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_release_ready", cmd_ready, 1'b1);
        check("bp_release_valid", rsp_valid, 1'b0);

        // IR-only command.
        vji_ir_out = 2'b10;
        cmd_ir = 2'b11;
        cmd_dr = 38'h3F_FFFF_FFFF;
        cmd_ir_only = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_ir_only = 1'b0;
        wait_rsp_a(lat);
        check("iro_latency", lat, 8);
        check("iro_ir_in", vji_ir_in, 2'b11);
        check("iro_rsp_ir_out", rsp_ir_out, 2'b10);
        check("iro_rsp_dr", rsp_dr, '0);
        check("iro_no_cdr_sdr_udr", n_cdr + n_sdr + n_udr, 0);
        check("iro_uir_rti", {n_uir[3:0], n_rti[3:0]}, 8'h11);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of SHIFT.
        cmd_ir = 2'b10;
        cmd_dr = 38'h15_5555_5555;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (60) step();
        check("mid_in_shift", vji_sdr, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_tck", vji_tck, 1'b0);
        check("mid_rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 5'b0);
        #2;
        reset_n = 1'b1;
        step();
        cmd_ir = 2'b01;
        cmd_dr = 38'h03_1234_5678;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_rsp_a(lat);
        check("post_rst_latency", lat, 168);
        check("post_rst_rsp_dr", rsp_dr, 38'h06_2468_ACF0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Back-to-back on the TCK_DIV=1 instance.
        b_ir = 2'b10;
        b_dr = 38'h1;
        b_valid = 1'b1;
        step();
        check("b2b_first_ir_in", b_ir_in, 2'b10);
        b_ir = 2'b01;
        b_dr = 38'h2;
        wait_rsp_b(lat);
        check("b2b_latency", lat, 84);
        check("b2b_uir_cycles", n_uir, 2);
        check("b2b_sdr_cycles", n_sdr, 76);
        repeat (3) step();
        check("b2b_held_ready", b_ready, 1'b0);
        check("b2b_held_ir_in", b_ir_in, 2'b10);
        b_rsp_ready = 1'b1;
        step();
        b_rsp_ready = 1'b0;
        check("b2b_consumed_ready", b_ready, 1'b1);
        check("b2b_consumed_ir_in", b_ir_in, 2'b10);
        step();
        b_valid = 1'b0;
        check("b2b_second_accept", b_ready, 1'b0);
        check("b2b_second_ir_in", b_ir_in, 2'b01);
        check("b2b_second_uir", b_uir, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
